debug_unit: RTL
===============

// Module: debug_unit
// PURPOSE
//  Run/step sequencer for the BIP-I core, driven by UART commands.
//  Sits between uart_rx/uart_tx and the CPU: gates the CPU enable, pulses the CPU soft-reset,
//  detects the HLT opcode, counts executed cycles and returns a 6-byte status frame over UART.
// PARAMETERS
//  PCLEN    11       program-counter width (zero-extended to 16 bits in the frame)
//  DBITS    16       accumulator width
//  CYCBITS  16       cycle-counter width
//  HLT_OP   5'b00000 opcode that ends a run
//  CMD_RUN  8'h52    'R' command byte
//  CMD_STEP 8'h53    'S' command byte (used only with DBG_STEP_EN)
// PORTS
//  i_clk      in   1        clock
//  i_rst      in   1        synchronous, active-high reset
//  i_rx_data  in   8        received byte, valid while i_rx_done=1
//  i_rx_done  in   1        one-cycle strobe, new byte from uart_rx
//  i_tx_done  in   1        one-cycle strobe, uart_tx finished the current byte
//  i_pc       in   PCLEN    CPU program counter (o_addr_pm)
//  i_acc      in   DBITS    CPU accumulator
//  i_opcode   in   5        opcode of the instruction currently fetched
//  o_cpu_en   out  1        CPU clock enable (PC/ACC/RAM writes gated by it)
//  o_cpu_rst  out  1        one-cycle CPU soft reset (PC <- 0, ACC <- 0)
//  o_tx_data  out  8        byte to send, stable from o_tx_start until i_tx_done
//  o_tx_start out  1        one-cycle strobe to uart_tx
//  o_busy     out  1        1 in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; o_cpu_en=0, o_cpu_rst=0, o_tx_start=0, o_tx_data=0, o_busy=0;
//   cycle counter and snapshot registers = 0. Reset mid-run or mid-frame aborts immediately.
//  FSM: IDLE -> CLR -> RUN -> SNAP -> TX <-> TXW -> IDLE (STEP path: IDLE -> STEP -> SNAP).
//  IDLE: i_rx_done && i_rx_data==CMD_RUN at T -> CLR at T+1. Other bytes ignored.
//  CLR: o_cpu_rst=1 for exactly one cycle (T+1); cycle counter <- 0; next RUN.
//  RUN: o_cpu_en=1 from T+2. Counter +1 per cycle with o_cpu_en=1, saturates at all-ones.
//   Cycle where o_cpu_en=1 and i_opcode==HLT_OP: counted, snapshot PC/ACC/counter
//   captured that cycle, o_cpu_en=0 from next edge, -> SNAP. No timeout: RUN lasts until HLT.
//  SNAP: one cycle; loads byte index 0; -> TX.
//  TX: o_tx_start=1 for one cycle, o_tx_data = frame[idx]; -> TXW.
//  TXW: hold o_tx_data; on i_tx_done: idx==5 -> IDLE, else idx+1 -> TX.
//   Two strobes never overlap; i_tx_done outside TXW is ignored.
//  Frame (MSB first): {PC[15:8],PC[7:0],ACC[15:8],ACC[7:0],CYC[15:8],CYC[7:0]},
//   PC zero-extended from PCLEN.
//  i_rx_done in any state other than IDLE: byte discarded, no queueing.
//  i_rx_done and i_tx_done in the same cycle: each handled by its own rule, no priority conflict.
// CONFIGURATION
//  DBG_STEP_EN defined:
//   IDLE + CMD_STEP -> STEP; o_cpu_en=1 for exactly one cycle, no soft reset,
//   counter +1 (saturating, not cleared); next cycle -> SNAP, which captures post-step PC/ACC.
//   A HLT fetched during a step is executed as a normal step (no extra effect).
//  DBG_STEP_EN undefined: CMD_STEP is ignored like any unknown byte; STEP state absent.
// TESTING
//  1 Program {LDI 5, ADDI 3, HLT}; send 'R' -> one o_cpu_rst pulse, o_cpu_en high 3 cycles,
//    frame 00 02 00 08 00 03.
//  2 Program HLT at addr 0; 'R' -> o_cpu_en high 1 cycle; frame 00 00 00 00 00 01.
//  3 Send 'X', then 'R' while in TXW -> both ignored; frame completes; state returns to IDLE.
//  4 Hold i_tx_done low 1000 cycles in TXW -> o_tx_data stable, no second o_tx_start;
//    release -> next byte.
//  5 Assert i_rst during RUN at cycle 40 -> next edge: o_cpu_en=0, o_busy=0;
//    a later 'R' restarts with counter=0.
//  6 DBG_STEP_EN: after reset, 'S' x2 on {LDI 7, ADDI 1} -> frames 00 01 00 07 00 01,
//    then 00 02 00 08 00 02; without macro 'S' -> no o_tx_start, o_busy stays 0.

Source files
------------

// File: rtl/debug_unit.sv
// debug_unit: UART-driven run/step sequencer for the BIP-I core; define DBG_STEP_EN to add the single-step command
module debug_unit #(
  parameter int PCLEN = 11,
  parameter int DBITS = 16,
  parameter int CYCBITS = 16,
  parameter logic [4:0] HLT_OP = 5'b00000,
`ifdef DBG_STEP_EN
  parameter logic [7:0] CMD_STEP = 8'h53,
`endif
  parameter logic [7:0] CMD_RUN = 8'h52
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  input  logic             i_tx_done,
  input  logic [PCLEN-1:0] i_pc,
  input  logic [DBITS-1:0] i_acc,
  input  logic [4:0]       i_opcode,
  output logic             o_cpu_en,
  output logic             o_cpu_rst,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  output logic             o_busy
);
`ifdef DBG_STEP_EN
  typedef enum logic [2:0] {IDLE, CLR, RUN, SNAP, TX, TXW, STEP} state_t;
`else
  typedef enum logic [2:0] {IDLE, CLR, RUN, SNAP, TX, TXW} state_t;
`endif
  state_t state, state_nx;
  logic [CYCBITS-1:0] cyc, cyc_inc, snap_cyc;
  logic [PCLEN-1:0] snap_pc;
  logic [DBITS-1:0] snap_acc;
  logic [2:0] idx;
  logic [47:0] frame;
  logic [5:0] sh;
  logic run_cmd, halt, from_step;
  assign run_cmd = i_rx_done && i_rx_data == CMD_RUN;
  assign halt = i_opcode == HLT_OP;
  assign cyc_inc = &cyc ? cyc : cyc + 1'b1;
  assign frame = {16'(snap_pc), 16'(snap_acc), 16'(snap_cyc)};
  assign sh = {3'd5 - idx, 3'b000};
  assign o_tx_data = (state == TX || state == TXW) ? frame[sh +: 8] : 8'h00;
`ifdef DBG_STEP_EN
  logic step_cmd;
  assign step_cmd = i_rx_done && i_rx_data == CMD_STEP;
  // remembers that SNAP follows a step, so it samples the post-step PC/ACC
  always_ff @(posedge i_clk)
    from_step <= !i_rst && state == STEP;
`else
  assign from_step = 1'b0;
`endif
  // state register
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_nx;
  // next state and Moore outputs
  always_comb begin
    state_nx = state;
    o_cpu_en = 1'b0;
    o_cpu_rst = 1'b0;
    o_tx_start = 1'b0;
    o_busy = state != IDLE;
    case (state)
`ifdef DBG_STEP_EN
      IDLE: state_nx = run_cmd ? CLR : step_cmd ? STEP : IDLE;
      STEP: begin
        o_cpu_en = 1'b1;
        state_nx = SNAP;
      end
`else
      IDLE: state_nx = run_cmd ? CLR : IDLE;
`endif
      CLR: begin
        o_cpu_rst = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        o_cpu_en = 1'b1;
        state_nx = halt ? SNAP : RUN;
      end
      SNAP: state_nx = TX;
      TX: begin
        o_tx_start = 1'b1;
        state_nx = TXW;
      end
      TXW: state_nx = !i_tx_done ? TXW : idx == 3'd5 ? IDLE : TX;
      default: state_nx = IDLE;
    endcase
  end
  // cycle counter, status snapshot and frame byte index
  always_ff @(posedge i_clk)
    if (i_rst) begin
      cyc <= '0;
      snap_pc <= '0;
      snap_acc <= '0;
      snap_cyc <= '0;
      idx <= '0;
    end else begin
      if (state == CLR) cyc <= '0;
      else if (o_cpu_en) cyc <= cyc_inc;
      if (state == RUN && halt) {snap_pc, snap_acc, snap_cyc} <= {i_pc, i_acc, cyc_inc};
      else if (state == SNAP && from_step) {snap_pc, snap_acc, snap_cyc} <= {i_pc, i_acc, cyc};
      if (state == SNAP) idx <= '0;
      else if (state == TXW && i_tx_done) idx <= idx + 1'b1;
    end
endmodule
